// File: rtl/gray_counter_param.sv
// Purpose: N-bit Gray-code counter with enable, up/down, sync load, binary mirror and wrap/saturate modes.
// Latency: one clock from en/load sampling to updated gray_out/bin_out/wrap; at_end is combinational from state.
// Backpressure: none; en gates counting every cycle and load pre-empts it.
module gray_counter_param #(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             wrap,
    output logic             at_end
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] bin_r;
    logic [WIDTH-1:0] gray_r;
    logic             wrap_r;
    logic [WIDTH-1:0] ld_bin;
    logic [WIDTH-1:0] bin_nxt;
    logic             wrap_nxt;

    // Bit i of the binary value is the XOR of all Gray bits at or above i.
    always_comb begin
        ld_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ld_bin[i] = ^(load_gray >> i);
        end
    end

    always_comb begin
        bin_nxt  = bin_r;
        wrap_nxt = 1'b0;
        if (load) begin
            bin_nxt = ld_bin;
        end else if (en) begin
            if (up_dn) begin
                if (bin_r != MAX_VAL) begin
                    bin_nxt = bin_r + ONE;
                end else if (!SATURATE) begin
                    bin_nxt  = '0;
                    wrap_nxt = 1'b1;
                end
            end else begin
                if (bin_r != '0) begin
                    bin_nxt = bin_r - ONE;
                end else if (!SATURATE) begin
                    bin_nxt  = MAX_VAL;
                    wrap_nxt = 1'b1;
                end
            end
        end
    end

    // Gray is registered alongside the binary so both outputs change on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_r  <= '0;
            gray_r <= '0;
            wrap_r <= 1'b0;
        end else begin
            bin_r  <= bin_nxt;
            gray_r <= bin_nxt ^ (bin_nxt >> 1);
            wrap_r <= wrap_nxt;
        end
    end

    assign gray_out = gray_r;
    assign bin_out  = bin_r;
    assign wrap     = wrap_r;
    assign at_end   = up_dn ? (bin_r == MAX_VAL) : (bin_r == '0);

endmodule

// File: tb/tb_gray_counter_param.sv
// Directed bench for gray_counter_param: a wrapping and a saturating 4-bit instance share one stimulus stream.
module tb_gray_counter_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_gray;

    logic [3:0] w_gray, w_bin, s_gray, s_bin;
    logic       w_wrap, w_end, s_wrap, s_end;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gray_counter_param #(.WIDTH(4), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_gray(load_gray),
        .gray_out(w_gray), .bin_out(w_bin), .wrap(w_wrap), .at_end(w_end)
    );

    gray_counter_param #(.WIDTH(4), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_gray(load_gray),
        .gray_out(s_gray), .bin_out(s_bin), .wrap(s_wrap), .at_end(s_end)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] gray_seq [16];
    logic [3:0] prev_gray;

    initial begin
        gray_seq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                     4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
        rst = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_gray = 4'h0;
        #3;
        chk("rst_gray", 16'(w_gray), 16'h0);
        chk("rst_bin", 16'(w_bin), 16'h0);
        chk("rst_wrap", 16'(w_wrap), 16'h0);
        chk("rst_at_end_up", 16'(w_end), 16'h0);
        up_dn = 1'b0;
        #1;
        chk("rst_at_end_dn", 16'(w_end), 16'h1);
        up_dn = 1'b1;

        // Count up through a full cycle and the wrap.
        step();
        rst = 1'b1; en = 1'b1; up_dn = 1'b1;
        prev_gray = w_gray;
        for (int k = 0; k < 16; k++) begin
            step();
            chk($sformatf("up_gray_%0d", k + 1), 16'(w_gray), 16'(gray_seq[k]));
            chk($sformatf("up_bin_%0d", k + 1), 16'(w_bin), 16'((k + 1) % 16));
            chk($sformatf("up_wrap_%0d", k + 1), 16'(w_wrap), (k == 15) ? 16'h1 : 16'h0);
            chk($sformatf("up_onebit_%0d", k + 1), 16'($countones(w_gray ^ prev_gray)), 16'h1);
            prev_gray = w_gray;
            if (k == 14) chk("up_at_end_15", 16'(w_end), 16'h1);
        end
        chk("sat_full_gray", 16'(s_gray), 16'h8);
        chk("sat_full_wrap", 16'(s_wrap), 16'h0);
        step();
        chk("up_wrap_single", 16'(w_wrap), 16'h0);

        // Down-count wrap from reset.
        rst = 1'b0; up_dn = 1'b0;
        #1;
        chk("dn_at_end_pre", 16'(w_end), 16'h1);
        chk("dn_rst_gray", 16'(w_gray), 16'h0);
        step();
        rst = 1'b1;
        step();
        chk("dn_gray", 16'(w_gray), 16'h8);
        chk("dn_bin", 16'(w_bin), 16'hF);
        chk("dn_wrap", 16'(w_wrap), 16'h1);
        chk("sat_dn_hold", 16'(s_gray), 16'h0);
        chk("sat_dn_wrap", 16'(s_wrap), 16'h0);
        step();
        chk("dn2_gray", 16'(w_gray), 16'h9);
        chk("dn2_bin", 16'(w_bin), 16'hE);
        chk("dn2_wrap", 16'(w_wrap), 16'h0);

        // Load has priority over en.
        load = 1'b1; load_gray = 4'hC; en = 1'b1; up_dn = 1'b1;
        step();
        chk("ld_gray", 16'(w_gray), 16'hC);
        chk("ld_bin", 16'(w_bin), 16'h8);
        chk("ld_wrap", 16'(w_wrap), 16'h0);
        load = 1'b0;
        step();
        chk("ld_next_gray", 16'(w_gray), 16'hD);
        chk("ld_next_bin", 16'(w_bin), 16'h9);

        // Enable gating holds state.
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("hold_gray_%0d", k), 16'(w_gray), 16'hD);
            chk($sformatf("hold_bin_%0d", k), 16'(w_bin), 16'h9);
            chk($sformatf("hold_wrap_%0d", k), 16'(w_wrap), 16'h0);
        end
        en = 1'b1;
        step();
        chk("resume_gray", 16'(w_gray), 16'hF);
        chk("resume_bin", 16'(w_bin), 16'hA);

        // Saturation at the top, then reversal.
        load = 1'b1; load_gray = 4'h8;
        step();
        chk("sat_ld_bin", 16'(s_bin), 16'hF);
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("sat_gray_%0d", k), 16'(s_gray), 16'h8);
            chk($sformatf("sat_at_end_%0d", k), 16'(s_end), 16'h1);
            chk($sformatf("sat_wrap_%0d", k), 16'(s_wrap), 16'h0);
            if (k == 0) chk("wrapinst_wrap", 16'(w_wrap), 16'h1);
        end
        up_dn = 1'b0;
        #1;
        chk("sat_at_end_dir", 16'(s_end), 16'h0);
        step();
        chk("sat_rev_gray", 16'(s_gray), 16'h9);
        chk("sat_rev_bin", 16'(s_bin), 16'hE);

        // Asynchronous reset mid-count.
        load = 1'b1; load_gray = 4'h4; up_dn = 1'b1;
        step();
        chk("ar_pre_bin", 16'(w_bin), 16'h7);
        load = 1'b0; load_gray = 4'hF;
        #2;
        rst = 1'b0;
        #1;
        chk("ar_gray", 16'(w_gray), 16'h0);
        chk("ar_bin", 16'(w_bin), 16'h0);
        chk("ar_wrap", 16'(w_wrap), 16'h0);
        load = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("ar_hold_%0d", k), 16'(w_bin), 16'h0);
        end
        load = 1'b0; rst = 1'b1; en = 1'b1; up_dn = 1'b1;
        step();
        chk("ar_resume_gray", 16'(w_gray), 16'h1);
        chk("ar_resume_bin", 16'(w_bin), 16'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
